// File: rtl/universal_shift_reg_n.sv
// N-bit universal shift register: hold, shift, rotate and parallel load, plus a
// counted burst of right shifts controlled by a two-state FSM.
module universal_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CW-1:0]    burst_len,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done,
  output logic             o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_BURST = 3'b110;

  localparam logic [CW-1:0] MAX_N = CW'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data,  w_data_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             r_done,  w_done_nxt;
  logic [WIDTH-1:0] w_shr;

  // "Right" moves bits toward the MSB; burst shifts reuse this path.
  assign w_shr = {r_data[WIDTH-2:0], serial_in_r};

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          case (mode)
            M_SHR:  w_data_nxt = w_shr;
            M_SHL:  w_data_nxt = {serial_in_l, r_data[WIDTH-1:1]};
            M_LOAD: w_data_nxt = parallel_in;
            M_ROR:  w_data_nxt = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            M_ROL:  w_data_nxt = {r_data[0], r_data[WIDTH-1:1]};
            M_BURST: begin
              if (start) begin
                if (burst_len == '0) begin
                  w_done_nxt = 1'b1;
                end else begin
                  w_state_nxt = S_BURST;
                  w_cnt_nxt   = (burst_len > MAX_N) ? MAX_N : burst_len;
                end
              end
            end
            default: w_data_nxt = r_data;
          endcase
        end
        S_BURST: begin
          // Mode/start/load inputs are deliberately ignored until the burst ends.
          w_data_nxt = w_shr;
          w_cnt_nxt  = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign parallel_out = r_data;
  assign serial_out   = r_data[WIDTH-1];
  assign serial_out_l = r_data[0];
  assign busy         = (r_state == S_BURST);
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule
